// File: rtl/glb_pulse_ctrl_if.sv
// Register bus between the processor-side master and the GLB pulse controller.
// The master drives strobes, address and write data; the controller returns
// registered read data with a one-cycle qualifier.
interface glb_pulse_ctrl_if #(
    parameter int CFG_ADDR_WIDTH = 8,
    parameter int CFG_DATA_WIDTH = 32
) ();

    logic                      cfg_wr_en;
    logic                      cfg_rd_en;
    logic [CFG_ADDR_WIDTH-1:0] cfg_addr;
    logic [CFG_DATA_WIDTH-1:0] cfg_wr_data;
    logic [CFG_DATA_WIDTH-1:0] cfg_rd_data;
    logic                      cfg_rd_data_valid;

    modport master (
        output cfg_wr_en,
        output cfg_rd_en,
        output cfg_addr,
        output cfg_wr_data,
        input  cfg_rd_data,
        input  cfg_rd_data_valid
    );

    modport slave (
        input  cfg_wr_en,
        input  cfg_rd_en,
        input  cfg_addr,
        input  cfg_wr_data,
        output cfg_rd_data,
        output cfg_rd_data_valid
    );

endinterface

// File: rtl/glb_pulse_ctrl.sv
// Global-controller end of the GLB tile start/interrupt pulse protocol.
// Register writes become per-tile stream / parallel-config start pulses; tile
// done pulses clear per-tile busy bits, set sticky done bits and feed a W1C
// interrupt status register that drives one registered level interrupt.
// Channels: c0 = strm_g2f, c1 = strm_f2g, c2 = pcfg.
// Optional feature: define GLB_PULSE_TIMEOUT_EN to add a per-channel watchdog
// (TIMEOUT register at 0x28, ISR/IER bits [11:9]).
module glb_pulse_ctrl #(
    parameter int NUM_GLB_TILES  = 16,
    parameter int CFG_ADDR_WIDTH = 8,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int TIMEOUT_WIDTH  = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    glb_pulse_ctrl_if.slave          cfg,
    output logic [NUM_GLB_TILES-1:0] strm_start_pulse,
    output logic [NUM_GLB_TILES-1:0] pc_start_pulse,
    input  logic [NUM_GLB_TILES-1:0] strm_f2g_interrupt_pulse,
    input  logic [NUM_GLB_TILES-1:0] strm_g2f_interrupt_pulse,
    input  logic [NUM_GLB_TILES-1:0] pcfg_g2f_interrupt_pulse,
    output logic                     interrupt
);

    localparam int N      = NUM_GLB_TILES;
    localparam int NUM_CH = 3;
    localparam int CH_G2F  = 0;
    localparam int CH_F2G  = 1;
    localparam int CH_PCFG = 2;

`ifdef GLB_PULSE_TIMEOUT_EN
    localparam int ISR_W = 12;
`else
    localparam int ISR_W = 9;
`endif

    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_IER        = CFG_ADDR_WIDTH'('h00);
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_ISR        = CFG_ADDR_WIDTH'('h04);
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_STRM_START = CFG_ADDR_WIDTH'('h08);
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_PC_START   = CFG_ADDR_WIDTH'('h0C);
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_BUSY0      = CFG_ADDR_WIDTH'('h10);
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_BUSY1      = CFG_ADDR_WIDTH'('h14);
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_BUSY2      = CFG_ADDR_WIDTH'('h18);
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_DONE0      = CFG_ADDR_WIDTH'('h1C);
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_DONE1      = CFG_ADDR_WIDTH'('h20);
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_DONE2      = CFG_ADDR_WIDTH'('h24);
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_TIMEOUT    = CFG_ADDR_WIDTH'('h28);

    // Per-channel tile vectors, indexed [channel][tile].
    logic [NUM_CH-1:0][N-1:0] irq;
    logic [NUM_CH-1:0][N-1:0] start_mask;
    logic [NUM_CH-1:0][N-1:0] accept;
    logic [NUM_CH-1:0][N-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0][N-1:0] done_q, done_d;

    logic [NUM_CH-1:0] reject_any;
    logic [NUM_CH-1:0] spurious_any;
    logic [NUM_CH-1:0] chan_done_evt;
    logic [NUM_CH-1:0] wr_done;
    logic [NUM_CH-1:0] timeout_evt;

    logic             wr_ier;
    logic             wr_isr;
    logic [ISR_W-1:0] ier_q;
    logic [ISR_W-1:0] isr_q, isr_d;
    logic [ISR_W-1:0] isr_set;
    logic [ISR_W-1:0] isr_clr;

    logic [CFG_DATA_WIDTH-1:0] rd_data_d;

    assign irq[CH_G2F]  = strm_g2f_interrupt_pulse;
    assign irq[CH_F2G]  = strm_f2g_interrupt_pulse;
    assign irq[CH_PCFG] = pcfg_g2f_interrupt_pulse;

    // Write decode: one-hot register selects and per-channel start masks.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ier     = 1'b0;
        wr_isr     = 1'b0;
        wr_done    = '0;
        start_mask = '0;
        if (cfg.cfg_wr_en) begin
            case (cfg.cfg_addr)
                ADDR_IER:        wr_ier = 1'b1;
                ADDR_ISR:        wr_isr = 1'b1;
                ADDR_STRM_START: begin
                    start_mask[CH_G2F] = cfg.cfg_wr_data[N-1:0];
                    start_mask[CH_F2G] = cfg.cfg_wr_data[2*N-1:N];
                end
                ADDR_PC_START:   start_mask[CH_PCFG] = cfg.cfg_wr_data[N-1:0];
                ADDR_DONE0:      wr_done[0] = 1'b1;
                ADDR_DONE1:      wr_done[1] = 1'b1;
                ADDR_DONE2:      wr_done[2] = 1'b1;
                default:         ;
            endcase
        end
    end

    // Per-channel busy/done bookkeeping. A start is accepted on an idle tile or
    // on a tile whose done pulse arrives in the same cycle; the accept wins
    // over the clear, so such a tile stays busy for the new job.
    always_comb begin
        accept        = '0;
        busy_d        = '0;
        done_d        = '0;
        reject_any    = '0;
        spurious_any  = '0;
        chan_done_evt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            accept[c]        = start_mask[c] & (~busy_q[c] | irq[c]);
            reject_any[c]    = |(start_mask[c] & busy_q[c] & ~irq[c]);
            spurious_any[c]  = |(irq[c] & ~busy_q[c]);
            busy_d[c]        = (busy_q[c] & ~irq[c]) | accept[c];
            chan_done_evt[c] = (busy_q[c] != '0) && (busy_d[c] == '0);
            // Hardware set is OR-ed in after the W1C clear so it wins.
            done_d[c]        = (done_q[c] & ~(wr_done[c] ? cfg.cfg_wr_data[N-1:0] : '0))
                               | irq[c];
        end
    end

`ifdef GLB_PULSE_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0]             timeout_q;
    logic [NUM_CH-1:0][TIMEOUT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
    logic                                 wr_timeout;

    assign wr_timeout = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_TIMEOUT);

    // Watchdog: count cycles a channel stays busy with no start or done
    // activity; hold at TIMEOUT and flag it. TIMEOUT of zero disables it.
    always_comb begin
        wd_cnt_d    = '0;
        timeout_evt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            timeout_evt[c] = (timeout_q != '0) && (wd_cnt_q[c] == timeout_q);
            if ((busy_q[c] == '0) || (accept[c] != '0) || (irq[c] != '0)) begin
                wd_cnt_d[c] = '0;
            end else if (timeout_evt[c]) begin
                wd_cnt_d[c] = wd_cnt_q[c];
            end else begin
                wd_cnt_d[c] = wd_cnt_q[c] + 1'b1;
            end
        end
    end

    // Watchdog counters and the TIMEOUT register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= '0;
            wd_cnt_q  <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            if (wr_timeout) begin
                timeout_q <= cfg.cfg_wr_data[TIMEOUT_WIDTH-1:0];
            end
        end
    end
`else
    assign timeout_evt = '0;
`endif

    // ISR next state: error and completion events set, W1C write clears.
    always_comb begin
        isr_set = '0;
        isr_set[2:0] = chan_done_evt;
        isr_set[5:3] = reject_any;
        isr_set[8:6] = spurious_any;
`ifdef GLB_PULSE_TIMEOUT_EN
        isr_set[11:9] = timeout_evt;
`endif
        isr_clr = wr_isr ? cfg.cfg_wr_data[ISR_W-1:0] : '0;
        isr_d   = (isr_q & ~isr_clr) | isr_set;
    end

    // Read mux; sampled with pre-write state so a coincident write is not seen.
    always_comb begin
        rd_data_d = '0;
        case (cfg.cfg_addr)
            ADDR_IER:     rd_data_d = CFG_DATA_WIDTH'(ier_q);
            ADDR_ISR:     rd_data_d = CFG_DATA_WIDTH'(isr_q);
            ADDR_BUSY0:   rd_data_d = CFG_DATA_WIDTH'(busy_q[0]);
            ADDR_BUSY1:   rd_data_d = CFG_DATA_WIDTH'(busy_q[1]);
            ADDR_BUSY2:   rd_data_d = CFG_DATA_WIDTH'(busy_q[2]);
            ADDR_DONE0:   rd_data_d = CFG_DATA_WIDTH'(done_q[0]);
            ADDR_DONE1:   rd_data_d = CFG_DATA_WIDTH'(done_q[1]);
            ADDR_DONE2:   rd_data_d = CFG_DATA_WIDTH'(done_q[2]);
`ifdef GLB_PULSE_TIMEOUT_EN
            ADDR_TIMEOUT: rd_data_d = CFG_DATA_WIDTH'(timeout_q);
`else
            ADDR_TIMEOUT: rd_data_d = CFG_DATA_WIDTH'({TIMEOUT_WIDTH{1'b0}});
`endif
            default:      rd_data_d = '0;
        endcase
    end

    // Status state: busy, done, IER and ISR.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            done_q <= '0;
            ier_q  <= '0;
            isr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            isr_q  <= isr_d;
            if (wr_ier) begin
                ier_q <= cfg.cfg_wr_data[ISR_W-1:0];
            end
        end
    end

    // Registered outputs: start pulses, read response and level interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strm_start_pulse      <= '0;
            pc_start_pulse        <= '0;
            cfg.cfg_rd_data       <= '0;
            cfg.cfg_rd_data_valid <= 1'b0;
            interrupt             <= 1'b0;
        end else begin
            strm_start_pulse      <= accept[CH_G2F] | accept[CH_F2G];
            pc_start_pulse        <= accept[CH_PCFG];
            cfg.cfg_rd_data_valid <= cfg.cfg_rd_en;
            cfg.cfg_rd_data       <= cfg.cfg_rd_en ? rd_data_d : '0;
            interrupt             <= |(isr_q & ier_q);
        end
    end

endmodule

// File: tb/tb_glb_pulse_ctrl.sv
// Self-checking bench for glb_pulse_ctrl. Stimulus pushes expected read data
// and expected start pulses into queues; a monitor pops and compares whenever
// the DUT presents read data or a start pulse.
module tb_glb_pulse_ctrl;

    localparam int N  = 16;
    localparam int AW = 8;
    localparam int DW = 32;

`ifdef GLB_PULSE_TIMEOUT_EN
    localparam logic [31:0] IER_ALL  = 32'h0000_0FFF;
    localparam logic [31:0] TO_READ  = 32'd100;
    localparam logic [31:0] TO_ISR   = 32'h0000_0800;
    localparam logic [31:0] TO_IRQ   = 32'd1;
`else
    localparam logic [31:0] IER_ALL  = 32'h0000_01FF;
    localparam logic [31:0] TO_READ  = 32'd0;
    localparam logic [31:0] TO_ISR   = 32'h0000_0000;
    localparam logic [31:0] TO_IRQ   = 32'd0;
`endif

    typedef struct {
        int          due;
        logic [31:0] data;
        string       name;
    } rd_exp_t;

    typedef struct {
        int          due;
        logic [15:0] strm;
        logic [15:0] pc;
    } pulse_exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  strm_start_pulse;
    logic [N-1:0]  pc_start_pulse;
    logic [N-1:0]  strm_f2g_interrupt_pulse = '0;
    logic [N-1:0]  strm_g2f_interrupt_pulse = '0;
    logic [N-1:0]  pcfg_g2f_interrupt_pulse = '0;
    logic          interrupt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    rd_exp_t    rd_q[$];
    pulse_exp_t pulse_q[$];

    glb_pulse_ctrl_if #(.CFG_ADDR_WIDTH(AW), .CFG_DATA_WIDTH(DW)) cfg_if ();

    glb_pulse_ctrl #(
        .NUM_GLB_TILES (N),
        .CFG_ADDR_WIDTH(AW),
        .CFG_DATA_WIDTH(DW),
        .TIMEOUT_WIDTH (24)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cfg                     (cfg_if),
        .strm_start_pulse        (strm_start_pulse),
        .pc_start_pulse          (pc_start_pulse),
        .strm_f2g_interrupt_pulse(strm_f2g_interrupt_pulse),
        .strm_g2f_interrupt_pulse(strm_g2f_interrupt_pulse),
        .pcfg_g2f_interrupt_pulse(pcfg_g2f_interrupt_pulse),
        .interrupt               (interrupt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare read data and start pulses against the queues.
    always @(negedge clk) begin
        if (cfg_if.cfg_rd_data_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=0x%0h expected=no_read", cfg_if.cfg_rd_data);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check({e.name, "_data"}, cfg_if.cfg_rd_data, e.data);
                check({e.name, "_cycle"}, cyc, e.due);
            end
        end
        if ((strm_start_pulse | pc_start_pulse) !== '0) begin
            if (pulse_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pulse_unexpected actual strm=0x%0h pc=0x%0h expected=none",
                         strm_start_pulse, pc_start_pulse);
            end else begin
                pulse_exp_t p;
                p = pulse_q.pop_front();
                check("strm_start_pulse", 32'(strm_start_pulse), 32'(p.strm));
                check("pc_start_pulse", 32'(pc_start_pulse), 32'(p.pc));
                check("pulse_cycle", cyc, p.due);
            end
        end
    end

    task automatic drive(input logic wr, input logic rd, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [15:0] g2f,
                         input logic [15:0] f2g, input logic [15:0] pcfg);
        cfg_if.cfg_wr_en         = wr;
        cfg_if.cfg_rd_en         = rd;
        cfg_if.cfg_addr          = addr;
        cfg_if.cfg_wr_data       = wdata;
        strm_g2f_interrupt_pulse = g2f;
        strm_f2g_interrupt_pulse = f2g;
        pcfg_g2f_interrupt_pulse = pcfg;
        @(posedge clk);
        #1;
        cfg_if.cfg_wr_en         = 1'b0;
        cfg_if.cfg_rd_en         = 1'b0;
        cfg_if.cfg_addr          = '0;
        cfg_if.cfg_wr_data       = '0;
        strm_g2f_interrupt_pulse = '0;
        strm_f2g_interrupt_pulse = '0;
        pcfg_g2f_interrupt_pulse = '0;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] data);
        drive(1'b1, 1'b0, addr, data, '0, '0, '0);
    endtask

    task automatic exp_rd(input string name, input logic [31:0] data);
        rd_exp_t e;
        e.due  = cyc + 1;
        e.data = data;
        e.name = name;
        rd_q.push_back(e);
    endtask

    task automatic rd_reg(input string name, input logic [7:0] addr, input logic [31:0] data);
        exp_rd(name, data);
        drive(1'b0, 1'b1, addr, '0, '0, '0, '0);
    endtask

    task automatic exp_pulse(input logic [15:0] strm, input logic [15:0] pc);
        pulse_exp_t p;
        p.due  = cyc + 1;
        p.strm = strm;
        p.pc   = pc;
        pulse_q.push_back(p);
    endtask

    task automatic irq(input logic [15:0] g2f, input logic [15:0] f2g, input logic [15:0] pcfg);
        drive(1'b0, 1'b0, 8'h00, '0, g2f, f2g, pcfg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        cfg_if.cfg_wr_en   = 1'b0;
        cfg_if.cfg_rd_en   = 1'b0;
        cfg_if.cfg_addr    = '0;
        cfg_if.cfg_wr_data = '0;

        // Reset state.
        idle(3);
        check("rst_strm_pulse", 32'(strm_start_pulse), 32'h0);
        check("rst_pc_pulse", 32'(pc_start_pulse), 32'h0);
        check("rst_interrupt", 32'(interrupt), 32'h0);
        check("rst_rd_valid", 32'(cfg_if.cfg_rd_data_valid), 32'h0);
        reset = 1'b1;
        idle(1);
        rd_reg("rst_isr", 8'h04, 32'h0);
        rd_reg("rst_busy2", 8'h18, 32'h0);

        // 1: parallel-config start on tiles 0 and 2, then their done pulses.
        wr_reg(8'h00, 32'h0000_0FFF);
        rd_reg("ier", 8'h00, IER_ALL);
        exp_pulse(16'h0000, 16'h0005);
        wr_reg(8'h0C, 32'h0000_0005);
        rd_reg("t1_busy2", 8'h18, 32'h5);
        rd_reg("t1_busy0", 8'h10, 32'h0);
        irq('0, '0, 16'h0005);
        rd_reg("t1_done2", 8'h24, 32'h5);
        rd_reg("t1_isr", 8'h04, 32'h4);
        check("t1_interrupt_set", 32'(interrupt), 32'h1);
        wr_reg(8'h04, 32'h4);
        rd_reg("t1_isr_clr", 8'h04, 32'h0);
        check("t1_interrupt_clr", 32'(interrupt), 32'h0);
        wr_reg(8'h24, 32'h5);
        rd_reg("t1_done2_clr", 8'h24, 32'h0);

        // 2: stream start g2f tile 0, f2g tiles 0-1; f2g completes first.
        exp_pulse(16'h0003, 16'h0000);
        wr_reg(8'h08, 32'h0003_0001);
        rd_reg("t2_busy0", 8'h10, 32'h1);
        rd_reg("t2_busy1", 8'h14, 32'h3);
        irq('0, 16'h0003, '0);
        rd_reg("t2_isr_f2g", 8'h04, 32'h2);
        rd_reg("t2_busy1_idle", 8'h14, 32'h0);
        rd_reg("t2_busy0_still", 8'h10, 32'h1);
        rd_reg("t2_done1", 8'h20, 32'h3);
        irq(16'h0001, '0, '0);
        rd_reg("t2_isr_both", 8'h04, 32'h3);
        wr_reg(8'h04, 32'h3);
        rd_reg("t2_isr_clr", 8'h04, 32'h0);

        // 3: restart of a busy tile is rejected; start with coincident done is accepted.
        exp_pulse(16'h0000, 16'h0001);
        wr_reg(8'h0C, 32'h1);
        wr_reg(8'h0C, 32'h1);
        rd_reg("t3_isr_restart", 8'h04, 32'h20);
        rd_reg("t3_busy2", 8'h18, 32'h1);
        exp_pulse(16'h0000, 16'h0001);
        drive(1'b1, 1'b0, 8'h0C, 32'h1, '0, '0, 16'h0001);
        rd_reg("t3_busy2_rearm", 8'h18, 32'h1);
        rd_reg("t3_isr_rearm", 8'h04, 32'h20);
        rd_reg("t3_done2", 8'h24, 32'h1);
        irq('0, '0, 16'h0001);
        rd_reg("t3_isr_done", 8'h04, 32'h24);
        wr_reg(8'h04, 32'h24);
        rd_reg("t3_isr_clr", 8'h04, 32'h0);

        // 4: spurious g2f pulse on idle tile 3; hardware set beats W1C.
        irq(16'h0008, '0, '0);
        rd_reg("t4_isr_spur", 8'h04, 32'h40);
        rd_reg("t4_done0", 8'h1C, 32'h9);
        drive(1'b1, 1'b0, 8'h04, 32'h40, 16'h0008, '0, '0);
        rd_reg("t4_isr_set_wins", 8'h04, 32'h40);
        drive(1'b1, 1'b0, 8'h1C, 32'h8, 16'h0008, '0, '0);
        rd_reg("t4_done_set_wins", 8'h1C, 32'h9);
        wr_reg(8'h04, 32'h40);
        rd_reg("t4_isr_clr", 8'h04, 32'h0);
        check("t4_interrupt_clr", 32'(interrupt), 32'h0);

        // 5: unmapped and write-only reads, read/write collision, reset mid-busy.
        rd_reg("t5_unmapped", 8'h3C, 32'h0);
        rd_reg("t5_wo_strm", 8'h08, 32'h0);
        exp_rd("t5_rdwr_old", IER_ALL);
        drive(1'b1, 1'b1, 8'h00, 32'h0000_0004, '0, '0, '0);
        rd_reg("t5_rdwr_new", 8'h00, 32'h4);
        wr_reg(8'h00, 32'h0000_01FF);
        exp_pulse(16'h0000, 16'h0002);
        wr_reg(8'h0C, 32'h2);
        exp_pulse(16'h0004, 16'h0000);
        wr_reg(8'h08, 32'h0000_0004);
        wr_reg(8'h0C, 32'h2);
        rd_reg("t5_isr_restart", 8'h04, 32'h20);
        rd_reg("t5_busy2", 8'h18, 32'h2);
        check("t5_interrupt_set", 32'(interrupt), 32'h1);
        idle(2);
        reset = 1'b0;
        #1;
        check("t5_rst_interrupt", 32'(interrupt), 32'h0);
        check("t5_rst_rd_valid", 32'(cfg_if.cfg_rd_data_valid), 32'h0);
        idle(2);
        reset = 1'b1;
        idle(1);
        rd_reg("t5_rst_busy0", 8'h10, 32'h0);
        rd_reg("t5_rst_busy2", 8'h18, 32'h0);
        rd_reg("t5_rst_isr", 8'h04, 32'h0);
        rd_reg("t5_rst_done0", 8'h1C, 32'h0);
        rd_reg("t5_rst_ier", 8'h00, 32'h0);
        check("t5_rst_interrupt_after", 32'(interrupt), 32'h0);

        // 6: watchdog on a pcfg job that never completes.
        wr_reg(8'h00, 32'h0000_0FFF);
        wr_reg(8'h28, 32'd100);
        rd_reg("t6_timeout_reg", 8'h28, TO_READ);
        exp_pulse(16'h0000, 16'h0001);
        wr_reg(8'h0C, 32'h1);
        idle(90);
        rd_reg("t6_isr_early", 8'h04, 32'h0);
        idle(15);
        rd_reg("t6_isr_timeout", 8'h04, TO_ISR);
        check("t6_interrupt", 32'(interrupt), TO_IRQ);

        idle(3);
        check("rd_pending", rd_q.size(), 32'h0);
        check("pulse_pending", pulse_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
